rvfi_pc_fwd_check: RTL and testbench
====================================

# rvfi_pc_fwd_check

Formal/simulation checker that verifies RVFI program-counter continuity in the forward direction: for the instruction with order N (retired on channel CHANNEL_IDX when `check` is high), its `rvfi_pc_rdata` must equal the `rvfi_pc_wdata` of the instruction with order N-1. It is the counterpart of the backward PC check, which compares in the other direction. It sits beside the other per-channel checks in the riscv-formal check wrapper and snoops all NRET retirement channels. It also exposes registered status flags so directed simulation benches can observe the verdicts.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `NRET`, 1 — number of RVFI retirement channels.
- `XLEN`, 32 — register and PC width.
- `CHANNEL_IDX`, 0 — channel carrying the checked instruction; must be below `NRET`.
- `PC_LSB_IGNORE`, 1 — number of PC LSBs excluded from comparison. The value 1 supports the C extension; 2 gives word-aligned comparison.

Ports:
- `clock` in 1 — the single clock.
- `reset` in 1 — synchronous, active-high.
- `check` in 1 — qualifies the cycle on which the target instruction is checked.
- `insn_order` in 64 — order of the target instruction; stable after reset.
- `rvfi_valid` in NRET — per-channel retire valid.
- `rvfi_order` in 64*NRET — per-channel instruction order.
- `rvfi_pc_rdata` in XLEN*NRET — per-channel PC of the instruction.
- `rvfi_pc_wdata` in XLEN*NRET — per-channel next PC.
- `armed` out 1 — the predecessor PC has been captured.
- `done` out 1 — the check has been evaluated (sticky).
- `fail` out 1 — PC mismatch detected (sticky).
- `dup_err` out 1 — the predecessor order was seen more than once (sticky).

## Operation
- Predecessor order: P = `insn_order` - 1, computed mod 2^64.
- State machine states: IDLE, ARMED, DONE. Reset value is IDLE.

State transitions:
- **IDLE → ARMED:** any valid channel has order == P and `check` is low. Capture that channel's `pc_wdata` into `expect_pc`.
- **IDLE/ARMED → DONE:** `check` is high. The following rules apply on this cycle:
  - Assume `rvfi_valid[CHANNEL_IDX]` is high and `rvfi_order[CHANNEL_IDX]` == `insn_order`.
  - The predecessor may retire in the same cycle only on a channel index below CHANNEL_IDX. Such a same-cycle hit overrides any stored `expect_pc`.
  - If a PC is known, compare `expect_pc` with `pc_rdata[CHANNEL_IDX]`, ignoring the low `PC_LSB_IGNORE` bits. On mismatch, set `fail` and `assert` false.
  - If no PC is known (including `insn_order` == 0), the check passes vacuously. `done` is set and `fail` stays 0.
- **DONE:** absorbing until reset. Later `check` pulses and later retirements are ignored.

Hit selection and duplicates:
- If several channels match P in one cycle, the lowest channel index wins.
- If P matches while in ARMED, or on two or more channels in one cycle, set `dup_err`. Keep the first captured PC.

## Timing
- All outputs are registered. Each flag updates on the clock edge that ends the qualifying cycle, so it is visible one cycle after the event.
- Reset values: `armed`=0, `done`=0, `fail`=0, `dup_err`=0, `expect_pc`=0, state=IDLE.
- Reset has priority over all other events in the same cycle. Reset while ARMED or DONE discards the capture.
- `armed` is 1 only in state ARMED, and 0 in DONE.
- Latency from the target retirement to `done` is 1 cycle. `fail` rises in the same cycle as `done`.
- No stalls and no backpressure; the block is purely observational.
- Wrap-around: when `insn_order` == 0, P = 2^64-1. Such an order is never produced in practice, so the check is vacuous.

## Structure
- Shared package `rvfi_check_pkg` holds:
  - the state enum `pc_chk_state_t` (IDLE, ARMED, DONE);
  - `ORDER_W` = 64;
  - a function `pc_eq_masked(a, b, lsb_ignore)`.
- One sub-module, `rvfi_order_match`:
  - inputs: a target order, an index limit, and the channel vectors;
  - outputs: `hit`, `multi_hit`, `hit_pc_wdata` from the lowest-index match among channels below the limit.
- The top-level instantiates `rvfi_order_match` twice:
  - limit `NRET`, used in non-check cycles;
  - limit `CHANNEL_IDX`, used in check cycles.

## Test plan
All scenarios use `NRET`=2 and `CHANNEL_IDX`=1 unless stated otherwise.
- **Pass:** order 4 retires with `pc_wdata`=0x104 → `armed`=1. Next cycle, `check` with order 5 and `pc_rdata`=0x104 → `done`=1, `fail`=0, `armed`=0.
- **Mismatch:** as above, but `pc_rdata`=0x108 → `done`=1, `fail`=1.
- **Same-cycle:**
  - Channel 0 retires order 4 with `pc_wdata`=0x200 while `check` is high on channel 1 with order 5 and `pc_rdata`=0x200 → pass.
  - With `CHANNEL_IDX`=0 and the predecessor on channel 1 in the same cycle → vacuous pass, `fail`=0.
- **Duplicate:** order 4 retires twice with PCs 0x100 then 0x300, then order 5 is checked with 0x100 → `dup_err`=1, `fail`=0.
- **Reset mid-check:** capture order 4, then pulse reset → all outputs 0. Then `check` order 5 with any PC → `done`=1, `fail`=0.
- **Order 0:** `check` with `insn_order`=0 → `done`=1, `fail`=0, `armed` never set.

Source files
------------

// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the RVFI program-counter continuity checks.
package rvfi_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } pc_chk_state_t;

  localparam int unsigned ORDER_W  = 64;
  localparam int unsigned PC_MAX_W = 64;

  // Equality of two PCs with the low lsb_ignore bits excluded.
  function automatic logic pc_eq_masked(input logic [PC_MAX_W-1:0] a,
                                        input logic [PC_MAX_W-1:0] b,
                                        input int unsigned lsb_ignore);
    logic eq;
    eq = 1'b1;
    for (int unsigned i = 0; i < PC_MAX_W; i++) begin
      if (i >= lsb_ignore && a[i] != b[i]) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/rvfi_order_match.sv
// Finds the lowest-index valid channel below LIMIT whose order equals target.
module rvfi_order_match
  import rvfi_check_pkg::*;
#(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LIMIT = NRET
) (
  input  logic [ORDER_W-1:0]      target,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
  output logic                    hit,
  output logic                    multi_hit,
  output logic [XLEN-1:0]         hit_pc_wdata
);

  always_comb begin
    hit          = 1'b0;
    multi_hit    = 1'b0;
    hit_pc_wdata = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (i < LIMIT && rvfi_valid[i] && rvfi_order[i*ORDER_W +: ORDER_W] == target) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          hit          = 1'b1;
          hit_pc_wdata = rvfi_pc_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_pc_fwd_check.sv
// Forward PC continuity check: pc_rdata of order N must equal pc_wdata of order N-1.
module rvfi_pc_fwd_check
  import rvfi_check_pkg::*;
#(
  parameter int unsigned NRET          = 1,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned CHANNEL_IDX   = 0,
  parameter int unsigned PC_LSB_IGNORE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    check,
  input  logic [ORDER_W-1:0]      insn_order,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
  output logic                    armed,
  output logic                    done,
  output logic                    fail,
  output logic                    dup_err
);

  pc_chk_state_t      state;
  logic [XLEN-1:0]    expect_pc;

  logic [ORDER_W-1:0] pred_order_c;
  logic               pred_ok_c;
  logic               all_hit, all_multi, early_hit, early_multi;
  logic [XLEN-1:0]    all_pc, early_pc;
  logic               all_hit_c, early_hit_c, pc_known_c, pc_match_c, dup_check_c;
  logic [XLEN-1:0]    ref_pc_c, pc_rdata_sel_c;

  // Order 0 has no real predecessor; its wrapped value must never match.
  assign pred_order_c = insn_order - ORDER_W'(1);
  assign pred_ok_c    = (insn_order != '0);

  rvfi_order_match #(.NRET(NRET), .XLEN(XLEN), .LIMIT(NRET)) u_match_all (
    .target        (pred_order_c),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .hit           (all_hit),
    .multi_hit     (all_multi),
    .hit_pc_wdata  (all_pc)
  );

  rvfi_order_match #(.NRET(NRET), .XLEN(XLEN), .LIMIT(CHANNEL_IDX)) u_match_early (
    .target        (pred_order_c),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .hit           (early_hit),
    .multi_hit     (early_multi),
    .hit_pc_wdata  (early_pc)
  );

  always_comb begin
    pc_rdata_sel_c = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (i == CHANNEL_IDX) pc_rdata_sel_c = rvfi_pc_rdata[i*XLEN +: XLEN];
    end
  end

  // A same-cycle predecessor on a lower channel takes precedence over the stored PC.
  assign all_hit_c   = pred_ok_c && all_hit;
  assign early_hit_c = pred_ok_c && early_hit;
  assign pc_known_c  = early_hit_c || (state == ARMED);
  assign ref_pc_c    = early_hit_c ? early_pc : expect_pc;
  assign pc_match_c  = pc_eq_masked(PC_MAX_W'(ref_pc_c), PC_MAX_W'(pc_rdata_sel_c), PC_LSB_IGNORE);
  assign dup_check_c = pred_ok_c && (early_multi || (early_hit && state == ARMED));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      expect_pc <= '0;
      armed     <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ARMED: begin
          if (check) begin
            state <= DONE;
            armed <= 1'b0;
            done  <= 1'b1;
            if (pc_known_c && !pc_match_c) fail <= 1'b1;
            if (dup_check_c) dup_err <= 1'b1;
          end else if (all_hit_c) begin
            if (state == IDLE) begin
              state     <= ARMED;
              armed     <= 1'b1;
              expect_pc <= all_pc;
              if (all_multi) dup_err <= 1'b1;
            end else begin
              dup_err <= 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FORMAL
  always_comb begin
    if (!reset && check && state != DONE) begin
      assume (rvfi_valid[CHANNEL_IDX] && rvfi_order[CHANNEL_IDX*ORDER_W +: ORDER_W] == insn_order);
      if (pc_known_c) assert (pc_match_c);
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_pc_fwd_check.sv
// Directed table-driven bench for rvfi_pc_fwd_check with NRET=2.
module tb_rvfi_pc_fwd_check;

  localparam logic [63:0] O4  = 64'd4;
  localparam logic [63:0] O5  = 64'd5;
  localparam logic [63:0] Z64 = 64'd0;
  localparam logic [31:0] Z32 = 32'd0;

  typedef struct {
    logic        rst;
    logic        chk;
    logic [63:0] ord;
    logic [1:0]  vld;
    logic [63:0] o0;
    logic [63:0] o1;
    logic [31:0] pr1;
    logic [31:0] pw0;
    logic [31:0] pw1;
    logic [3:0]  exp;   // {armed, done, fail, dup_err}
  } vec_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         check;
  logic [63:0]  insn_order;
  logic [1:0]   rvfi_valid;
  logic [127:0] rvfi_order;
  logic [63:0]  rvfi_pc_rdata;
  logic [63:0]  rvfi_pc_wdata;
  logic         armed0, done0, fail0, dup0;
  logic         armed1, done1, fail1, dup1;

  int checks = 0;
  int errors = 0;
  vec_t tv[$];

  always #5 clock = ~clock;

  rvfi_pc_fwd_check #(.NRET(2), .XLEN(32), .CHANNEL_IDX(1), .PC_LSB_IGNORE(1)) dut (
    .clock(clock), .reset(reset), .check(check), .insn_order(insn_order),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .armed(armed0), .done(done0), .fail(fail0), .dup_err(dup0)
  );

  rvfi_pc_fwd_check #(.NRET(2), .XLEN(32), .CHANNEL_IDX(0), .PC_LSB_IGNORE(1)) dut_ch0 (
    .clock(clock), .reset(reset), .check(check), .insn_order(insn_order),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .armed(armed1), .done(done1), .fail(fail1), .dup_err(dup1)
  );

  function automatic vec_t mk(input logic rst, input logic chk, input logic [63:0] ord,
                              input logic [1:0] vld, input logic [63:0] o0, input logic [63:0] o1,
                              input logic [31:0] pr1, input logic [31:0] pw0, input logic [31:0] pw1,
                              input logic [3:0] exp);
    vec_t v;
    v.rst = rst; v.chk = chk; v.ord = ord; v.vld = vld; v.o0 = o0; v.o1 = o1;
    v.pr1 = pr1; v.pw0 = pw0; v.pw1 = pw1; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic chk, input logic [63:0] ord,
                       input logic [1:0] vld, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [31:0] pr0, input logic [31:0] pr1,
                       input logic [31:0] pw0, input logic [31:0] pw1);
    reset         = rst;
    check         = chk;
    insn_order    = ord;
    rvfi_valid    = vld;
    rvfi_order    = {o1, o0};
    rvfi_pc_rdata = {pr1, pr0};
    rvfi_pc_wdata = {pw1, pw0};
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got armed/done/fail/dup=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // Pass, ignored later traffic, then mismatch with capture on channel 1
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h104, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h104, Z32, Z32, 4'b0100));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h108, Z32, Z32, 4'b0100));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h999, Z32, 4'b0100));
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b10, Z64, O4,  Z32, Z32, 32'h104, 4'b1000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h108, Z32, Z32, 4'b0110));
    // Same-cycle predecessor on channel 0: match then mismatch
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b11, O4,  O5,  32'h200, 32'h200, Z32, 4'b0100));
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b11, O4,  O5,  32'h204, 32'h200, Z32, 4'b0110));
    // Duplicate across cycles keeps the first PC
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h100, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b10, Z64, O4,  Z32, Z32, 32'h300, 4'b1001));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h100, Z32, Z32, 4'b0101));
    // Reset discards capture; later check is vacuous
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h104, Z32, 4'b1000));
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'hdeadbeef, Z32, Z32, 4'b0100));
    // Bit 0 ignored, bit 1 compared
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h104, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h105, Z32, Z32, 4'b0100));
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h104, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h106, Z32, Z32, 4'b0110));
    // Two channels hit in one cycle: lowest wins, dup flagged
    tv.push_back(mk(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b11, O4,  O4,  Z32, 32'h400, 32'h500, 4'b1001));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b10, Z64, O5,  32'h400, Z32, Z32, 4'b0101));
    // Reset wins over a simultaneous check
    tv.push_back(mk(1'b1, 1'b1, O5, 2'b10, Z64, O5,  32'h999, Z32, Z32, 4'b0000));
    // Same-cycle hit while armed overrides stored PC and flags dup
    tv.push_back(mk(1'b0, 1'b0, O5, 2'b01, O4,  Z64, Z32, 32'h104, Z32, 4'b1000));
    tv.push_back(mk(1'b0, 1'b1, O5, 2'b11, O4,  O5,  32'h208, 32'h208, Z32, 4'b0101));
    // Order 0: wrapped predecessor never arms, check is vacuous
    tv.push_back(mk(1'b1, 1'b0, Z64, 2'b00, Z64, Z64, Z32, Z32, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b0, Z64, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, Z64, Z32, 32'h104, Z32, 4'b0000));
    tv.push_back(mk(1'b0, 1'b1, Z64, 2'b10, Z64, Z64, 32'h123, Z32, Z32, 4'b0100));

    drive(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, Z32);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].chk, tv[i].ord, tv[i].vld, tv[i].o0, tv[i].o1,
            Z32, tv[i].pr1, tv[i].pw0, tv[i].pw1);
      cmp($sformatf("vec%0d", i), {armed0, done0, fail0, dup0}, tv[i].exp);
    end

    // CHANNEL_IDX=0: predecessor on channel 1 in the check cycle cannot be used
    drive(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, Z32);
    cmp("ch0_reset", {armed1, done1, fail1, dup1}, 4'b0000);
    drive(1'b0, 1'b1, O5, 2'b11, O5, O4, 32'h999, Z32, Z32, 32'h200);
    cmp("ch0_vacuous", {armed1, done1, fail1, dup1}, 4'b0100);

    // CHANNEL_IDX=0: earlier capture from channel 1, then mismatch on channel 0
    drive(1'b1, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, Z32);
    drive(1'b0, 1'b0, O5, 2'b10, Z64, O4, Z32, Z32, Z32, 32'h300);
    cmp("ch0_armed", {armed1, done1, fail1, dup1}, 4'b1000);
    drive(1'b0, 1'b0, O5, 2'b00, Z64, Z64, Z32, Z32, Z32, Z32);
    cmp("ch0_hold", {armed1, done1, fail1, dup1}, 4'b1000);
    drive(1'b0, 1'b1, O5, 2'b01, O5, Z64, 32'h304, Z32, Z32, Z32);
    cmp("ch0_mismatch", {armed1, done1, fail1, dup1}, 4'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
